ccff_loader: RTL and testbench



---
 rtl/ccff_pkg.sv | 22 ++
 rtl/ccff_crc8.sv | 27 ++
 rtl/ccff_loader.sv | 195 +++++++++++++++++++
 tb/tb_ccff_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and CRC-8 helper for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StVerify,
    StFin
  } ccff_state_t;

  localparam logic [7:0] Crc8PolyDefault = 8'h07;
  localparam logic [7:0] Crc8Init        = 8'h00;

  // MSB-first, unreflected, one input bit per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Bit-serial CRC-8 register with synchronous clear and step enable.
module ccff_crc8
  import ccff_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = Crc8PolyDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= Crc8Init;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, din, CRC_POLY);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Serialises a byte stream MSB-first into a configuration flip-flop chain and
// optionally recirculates the chain once to confirm its contents by CRC-8.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 36,
  parameter logic [7:0]  CRC_POLY  = Crc8PolyDefault
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       start,
  input  logic       verify_en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       ccff_clk_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] crc_out
);

  localparam int unsigned NumBytes = (CHAIN_LEN + 7) / 8;
  localparam int unsigned BitCntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned ByteCntW = $clog2(NumBytes + 1);

  localparam logic [BitCntW-1:0]  LenBits  = BitCntW'(CHAIN_LEN);
  localparam logic [BitCntW-1:0]  LenLast  = BitCntW'(CHAIN_LEN - 1);
  localparam logic [BitCntW-1:0]  BitOne   = BitCntW'(1);
  localparam logic [ByteCntW-1:0] NumBytesW = ByteCntW'(NumBytes);
  localparam logic [ByteCntW-1:0] ByteOne  = ByteCntW'(1);

  ccff_state_t         state_q;
  logic                verify_q;
  logic [7:0]          buf_q;
  logic                buf_valid_q;
  logic [7:0]          sr_q;
  logic [2:0]          sr_cnt_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic [ByteCntW-1:0] byte_cnt_q;
  logic                head_q;
  logic                clk_en_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [7:0]          crc_out_q;

  logic       ready_int;
  logic       accept;
  logic       sr_has;
  logic       emit;
  logic       emit_bit;
  logic       ver_shift;
  logic       crc_clr;
  logic [7:0] crc_load;
  logic [7:0] crc_ver;
  logic [7:0] crc_ver_next;

  always_comb begin
    ready_int = (state_q == StLoad) && !buf_valid_q && (byte_cnt_q < NumBytesW);
    accept    = in_valid && ready_int;
    sr_has    = (sr_cnt_q != 3'd0);
    // A bit is available from the shift register, or straight from the buffer
    // when the shift register has just drained; stops once the chain is full.
    emit      = (state_q == StLoad) && (bit_cnt_q < LenBits) && (sr_has || buf_valid_q);
    emit_bit  = sr_has ? sr_q[7] : buf_q[7];
    ver_shift = (state_q == StVerify) && clk_en_q;
    crc_clr   = (state_q == StIdle) && start;
  end

  assign crc_ver_next = crc8_step(crc_ver, ccff_tail, CRC_POLY);

  ccff_crc8 #(
    .CRC_POLY (CRC_POLY)
  ) u_crc_load (
    .clk (prog_clk),
    .rst (prog_reset),
    .clr (crc_clr),
    .en  (emit),
    .din (emit_bit),
    .crc (crc_load)
  );

  ccff_crc8 #(
    .CRC_POLY (CRC_POLY)
  ) u_crc_ver (
    .clk (prog_clk),
    .rst (prog_reset),
    .clr (crc_clr),
    .en  (ver_shift),
    .din (ccff_tail),
    .crc (crc_ver)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= StIdle;
      verify_q    <= 1'b0;
      buf_q       <= 8'h00;
      buf_valid_q <= 1'b0;
      sr_q        <= 8'h00;
      sr_cnt_q    <= 3'd0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      crc_out_q   <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          head_q   <= 1'b0;
          clk_en_q <= 1'b0;
          if (start) begin
            state_q     <= StLoad;
            busy_q      <= 1'b1;
            verify_q    <= verify_en;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            buf_valid_q <= 1'b0;
            sr_cnt_q    <= 3'd0;
            pass_q      <= 1'b0;
            crc_out_q   <= 8'h00;
          end
        end
        StLoad: begin
          // accept needs an empty buffer, a buffer-to-shifter move needs a full
          // one, so the two buf_valid_q updates below never collide.
          if (accept) begin
            buf_q       <= in_data;
            buf_valid_q <= 1'b1;
            byte_cnt_q  <= byte_cnt_q + ByteOne;
          end
          clk_en_q <= emit;
          if (emit) begin
            head_q    <= emit_bit;
            bit_cnt_q <= bit_cnt_q + BitOne;
            if (sr_has) begin
              sr_q     <= {sr_q[6:0], 1'b0};
              sr_cnt_q <= sr_cnt_q - 3'd1;
            end else begin
              sr_q        <= {buf_q[6:0], 1'b0};
              sr_cnt_q    <= 3'd7;
              buf_valid_q <= 1'b0;
            end
          end
          if (bit_cnt_q == LenBits) begin
            bit_cnt_q <= '0;
            head_q    <= 1'b0;
            crc_out_q <= crc_load;
            clk_en_q  <= verify_q;
            if (verify_q) begin
              state_q <= StVerify;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end
        end
        StVerify: begin
          if (clk_en_q) begin
            bit_cnt_q <= bit_cnt_q + BitOne;
            if (bit_cnt_q == LenLast) begin
              clk_en_q <= 1'b0;
              state_q  <= StFin;
              done_q   <= 1'b1;
              pass_q   <= (crc_ver_next == crc_load);
            end
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready    = ready_int;
  // During verify the chain is closed into a ring through the loader.
  assign ccff_head   = (state_q == StVerify) ? ccff_tail : head_q;
  assign ccff_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign crc_out     = crc_out_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader driving a 36-stage chain model.
module tb_ccff_loader;

  localparam int ChainLen = 36;

  logic       prog_clk;
  logic       prog_reset;
  logic       start;
  logic       verify_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ccff_head;
  logic       ccff_tail;
  logic       ccff_clk_en;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] crc_out;

  ccff_loader #(
    .CHAIN_LEN (ChainLen),
    .CRC_POLY  (8'h07)
  ) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .start       (start),
    .verify_en   (verify_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .ccff_clk_en (ccff_clk_en),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .crc_out     (crc_out)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Chain model: shifts only on enabled edges; tail can be forced high.
  logic [ChainLen-1:0] chain = '0;
  logic                stuck = 1'b0;
  always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[ChainLen-2:0], ccff_head};
  assign ccff_tail = stuck ? 1'b1 : chain[ChainLen-1];

  typedef struct {
    logic [ChainLen-1:0] chain;
    logic [7:0]          crc;
    logic                pass;
    logic                chk_lat;
    int                  lat;
    int                  pulses;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   first_acc = 0;
  logic got_first = 1'b0;
  int   done_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [ChainLen-1:0] bits);
    logic [7:0] c;
    c = 8'h00;
    for (int i = ChainLen - 1; i >= 0; i--) begin
      c = (c[7] ^ bits[i]) ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (start && !busy) begin
      pulses    <= 0;
      got_first <= 1'b0;
    end else begin
      if (ccff_clk_en) pulses <= pulses + 1;
      if (in_valid && in_ready && !got_first) begin
        got_first <= 1'b1;
        first_acc <= cyc + 1;
      end
    end
  end

  always @(negedge prog_clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'(done), 64'd0);
      end else begin
        check_eq("crc_out", 64'(crc_out), 64'(sb_q[0].crc));
        check_eq("pass", 64'(pass), 64'(sb_q[0].pass));
        check_eq("chain", 64'(chain), 64'(sb_q[0].chain));
        check_eq("shift_pulses", 64'(pulses), 64'(sb_q[0].pulses));
        if (sb_q[0].chk_lat) check_eq("done_latency", 64'(cyc - first_acc), 64'(sb_q[0].lat));
        sb_q.delete(0);
      end
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic feed_bytes(input logic [39:0] stream, input int nbytes, input int max_gap,
                            input logic extra);
    for (int i = 0; i < nbytes; i++) begin
      int gap;
      int t;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) @(negedge prog_clk);
      in_valid = 1'b1;
      in_data  = stream[39-8*i -: 8];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge prog_clk);
        t++;
      end
      if (t >= 50) check_eq("ready_timeout", 64'(in_ready), 64'd1);
      @(negedge prog_clk);
      in_valid = 1'b0;
      if (extra && i == 1) begin
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic run_load(input logic [39:0] stream, input logic ver, input logic stk,
                          input int max_gap, input logic extra);
    exp_t e;
    logic [ChainLen-1:0] bits;
    logic [ChainLen-1:0] tail_bits;
    int n0;
    int t;
    bits      = stream[39:4];
    tail_bits = stk ? '1 : bits;
    e.crc     = ref_crc(bits);
    e.pass    = !ver || (ref_crc(tail_bits) == e.crc);
    e.chain   = (ver && stk) ? '1 : bits;
    e.chk_lat = (max_gap == 0);
    e.lat     = ver ? 2 * ChainLen + 1 : ChainLen + 1;
    e.pulses  = ver ? 2 * ChainLen : ChainLen;
    sb_q.push_back(e);
    stuck = stk;
    n0 = done_cnt;
    @(negedge prog_clk);
    start     = 1'b1;
    verify_en = ver;
    @(negedge prog_clk);
    start     = 1'b0;
    verify_en = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    check_eq("ready_after_start", 64'(in_ready), 64'd1);
    feed_bytes(stream, 5, max_gap, extra);
    if (extra) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end
    t = 0;
    while (done_cnt == n0 && t < 300) begin
      if (extra) check_eq("ready_after_last", 64'(in_ready), 64'd0);
      @(negedge prog_clk);
      t++;
    end
    if (done_cnt == n0) begin
      check_eq("done_timeout", 64'(done_cnt - n0), 64'd1);
      sb_q.delete();
    end
    in_valid = 1'b0;
    stuck    = 1'b0;
    @(negedge prog_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_head"}, 64'(ccff_head), 64'd0);
    check_eq({tag, "_clk_en"}, 64'(ccff_clk_en), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_pass"}, 64'(pass), 64'd0);
    check_eq({tag, "_crc_out"}, 64'(crc_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [39:0] stream;
    int n0;
    int t;
    prog_reset = 1'b1;
    start      = 1'b0;
    verify_en  = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    repeat (3) @(negedge prog_clk);
    check_reset_outputs("rst");
    prog_reset = 1'b0;

    stream = 40'hA5_3C_0F_F0_9F;
    run_load(stream, 1'b0, 1'b0, 0, 1'b1);
    run_load(stream, 1'b1, 1'b0, 0, 1'b0);
    run_load(40'h0, 1'b1, 1'b1, 0, 1'b0);
    run_load(stream, 1'b0, 1'b0, 3, 1'b0);

    // Reset in the middle of a load, after 20 chain shifts.
    n0 = done_cnt;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    feed_bytes(stream, 3, 0, 1'b0);
    t = 0;
    while (pulses < 20 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check_eq("pulses_before_reset", 64'(pulses), 64'd20);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    check_reset_outputs("midrst");
    prog_reset = 1'b0;
    repeat (60) @(negedge prog_clk);
    check_eq("no_done_after_reset", 64'(done_cnt), 64'(n0));

    run_load(40'h5A_C3_96_E1_70, 1'b1, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
